// File: rtl/video_capture.sv
// Parallel RGB video sink: registers the incoming pixel bus, recovers x/y from
// sync and data-enable edges, emits framebuffer writes and measures geometry.
module video_capture #(
    parameter int unsigned MAX_W       = 256,
    parameter int unsigned MAX_H       = 240,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  in_red,
    input  logic [7:0]  in_green,
    input  logic [7:0]  in_blue,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_blank,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] meas_width,
    output logic [15:0] meas_height,
    output logic [15:0] meas_htotal,
    output logic        locked,
    output logic        err_overflow
);

    localparam logic [15:0] MaxW       = 16'(MAX_W);
    localparam logic [15:0] MaxH       = 16'(MAX_H);
    localparam logic [15:0] LockFrames = 16'(LOCK_FRAMES);

    typedef enum logic [0:0] {StSearch, StCapture} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] pix_q, pix_d;
    logic        hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, bl_prev_q, bl_prev_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [15:0] hcnt_q, hcnt_d, htot_q, htot_d;
    logic [15:0] w0_q, w0_d;
    logic        mism_q, mism_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [23:0] wr_data_q, wr_data_d;
    logic        fs_q, fs_d, fd_q, fd_d;
    logic [15:0] meas_w_q, meas_w_d, meas_h_q, meas_h_d, meas_ht_q, meas_ht_d;
    logic [15:0] cnt_q, cnt_d;
    logic        locked_q, locked_d;
    logic        prev_valid_q, prev_valid_d;
    logic        err_q, err_d;

    // Scratch values for the combinational block
    logic        ev_vs, ev_hs, ev_def, line_open, capturing, geom_eq;
    logic [15:0] x_cl, y_cl, w0_cl, ht_cl, x_px, y_px, cnt_n;
    logic        mism_cl;

    // State register: every flop clears on asynchronous reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StSearch;
            pix_q        <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            bl_q         <= 1'b0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            bl_prev_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            hcnt_q       <= '0;
            htot_q       <= '0;
            w0_q         <= '0;
            mism_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            fs_q         <= 1'b0;
            fd_q         <= 1'b0;
            meas_w_q     <= '0;
            meas_h_q     <= '0;
            meas_ht_q    <= '0;
            cnt_q        <= '0;
            locked_q     <= 1'b0;
            prev_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            bl_q         <= bl_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            bl_prev_q    <= bl_prev_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hcnt_q       <= hcnt_d;
            htot_q       <= htot_d;
            w0_q         <= w0_d;
            mism_q       <= mism_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            fs_q         <= fs_d;
            fd_q         <= fd_d;
            meas_w_q     <= meas_w_d;
            meas_h_q     <= meas_h_d;
            meas_ht_q    <= meas_ht_d;
            cnt_q        <= cnt_d;
            locked_q     <= locked_d;
            prev_valid_q <= prev_valid_d;
            err_q        <= err_d;
        end
    end

    // Next-state: input stage, position tracking, writes, measurement and lock FSM
    always_comb begin
        pix_d        = {in_red, in_green, in_blue};
        hs_d         = in_hsync;
        vs_d         = in_vsync;
        bl_d         = in_blank;
        hs_prev_d    = hs_q;
        vs_prev_d    = vs_q;
        bl_prev_d    = bl_q;
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        fs_d         = 1'b0;
        fd_d         = 1'b0;
        meas_w_d     = meas_w_q;
        meas_h_d     = meas_h_q;
        meas_ht_d    = meas_ht_q;
        cnt_d        = cnt_q;
        locked_d     = locked_q;
        prev_valid_d = prev_valid_q;
        err_d        = err_q;
        cnt_n        = '0;

        ev_vs  = vs_prev_q & ~vs_q;
        ev_hs  = hs_prev_q & ~hs_q;
        ev_def = bl_prev_q & ~bl_q;

        // Close the current line first, then let VS open a fresh frame
        line_open = (x_q != 16'd0);
        x_cl      = ev_def ? 16'd0 : x_q;
        y_cl      = (ev_def && line_open) ? sat_inc(y_q) : y_q;
        w0_cl     = (ev_def && line_open && y_q == 16'd0) ? x_q : w0_q;
        mism_cl   = mism_q | (ev_def && line_open && y_q != 16'd0 && x_q != w0_q);
        ht_cl     = ev_hs ? hcnt_q : htot_q;
        hcnt_d    = ev_hs ? 16'd1 : sat_inc(hcnt_q);
        htot_d    = ht_cl;
        geom_eq   = (w0_cl == meas_w_q) && (y_cl == meas_h_q) && (ht_cl == meas_ht_q);

        x_px   = ev_vs ? 16'd0 : x_cl;
        y_px   = ev_vs ? 16'd0 : y_cl;
        x_d    = x_px;
        y_d    = y_px;
        w0_d   = ev_vs ? 16'd0 : w0_cl;
        mism_d = ev_vs ? 1'b0 : mism_cl;

        capturing = (state_q == StCapture) && enable;
        if (bl_q) begin
            x_d = sat_inc(x_px);
            if (capturing) begin
                if (x_px < MaxW && y_px < MaxH) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {y_px[7:0], x_px[7:0]};
                    wr_data_d = pix_q;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            StSearch: begin
                if (enable && ev_vs) begin
                    state_d      = StCapture;
                    fs_d         = 1'b1;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                end
            end
            StCapture: begin
                if (!enable) begin
                    state_d      = StSearch;
                    locked_d     = 1'b0;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                end else if (ev_vs) begin
                    fs_d      = 1'b1;
                    fd_d      = 1'b1;
                    meas_w_d  = w0_cl;
                    meas_h_d  = y_cl;
                    meas_ht_d = ht_cl;
                    // First frame has nothing to compare against; only line consistency counts
                    if (mism_cl) begin
                        cnt_n = '0;
                    end else if (!prev_valid_q) begin
                        cnt_n = 16'd1;
                    end else if (geom_eq) begin
                        cnt_n = sat_inc(cnt_q);
                    end else begin
                        cnt_n = '0;
                    end
                    cnt_d        = cnt_n;
                    locked_d     = (cnt_n != 16'd0) && (cnt_n >= LockFrames);
                    prev_valid_d = 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_start  = fs_q;
    assign frame_done   = fd_q;
    assign meas_width   = meas_w_q;
    assign meas_height  = meas_h_q;
    assign meas_htotal  = meas_ht_q;
    assign locked       = locked_q;
    assign err_overflow = err_q;

endmodule
